// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
// Load/store sequencer between the core memory stage and a word-only data
// memory. It converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into full-word
// memory accesses:
// - Sub-word stores become a read-modify-write sequence.
// - Loads are lane-extracted and sign/zero-extended.
// - Misaligned, out-of-range and illegal-funct3 requests get an error response
//   without touching memory.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3         direction and RV32I access size/sign
//   req_addr, req_wdata        byte address, store data (low bits used)
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata, rsp_err         extended load data (0 for stores/errors), error
//   mem_read, mem_write        DMEM strobes (never both high)
//   mem_addr, mem_wdata        word-aligned DMEM address, write data
//   mem_rdata                  combinational DMEM read data
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_err;
  logic        w_accept;

  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  // Request classification: illegal funct3 for the direction, misalignment
  // for halfword/word sizes, or a byte address beyond the memory.
  function automatic logic req_is_err(input logic        we,
                                      input logic [2:0]  f3,
                                      input logic [31:0] a);
    logic bad_f3;
    logic bad_align;
    if (we) begin
      bad_f3 = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
    end else begin
      bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    case (f3[1:0])
      2'b01:   bad_align = a[0];
      2'b10:   bad_align = (a[1:0] != 2'b00);
      default: bad_align = 1'b0;
    endcase
    return bad_f3 | bad_align | (a >= MEM_BYTES);
  endfunction

  // Pick the addressed byte/halfword lane out of a memory word and extend it.
  // funct3[2] selects zero extension (LBU/LHU).
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0000, h};
      default: return word;
    endcase
  endfunction

  // Overlay the store byte/halfword onto the word read back from memory,
  // keeping the untouched lanes.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00) begin
      m[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (f3[1:0] == 2'b01) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end
    return m;
  endfunction

  assign w_err    = req_is_err(req_we, req_funct3, req_addr);
  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_err)                     w_next = S_RESP;
          else if (!req_we)              w_next = S_LOAD;
          else if (req_funct3 == 3'b010) w_next = S_WR;
          else                           w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WR;
      S_WR:     w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are pure functions of the state register, so an asynchronous
  // reset removes mem_write in the same instant and no partial RMW commits.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_LOAD, S_RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = {r_addr[31:2], 2'b00};
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_wdata = r_merge;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= 32'h0000_0000;
      end else if (r_state == S_LOAD) begin
        r_rdata <= load_extract(mem_rdata, r_funct3, r_addr[1:0]);
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rdata <= 32'h0000_0000;
        r_err   <= 1'b0;
      end
    end
  end

  // Request datapath registers; only meaningful while a request is in flight.
  // The merge word starts as the full store data so SW goes straight to WR.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_merge  <= req_wdata;
    end else if (r_state == S_RMW_RD) begin
      r_merge  <= merge_store(mem_rdata, r_wdata, r_funct3, r_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu_ctrl
// Directed bench for dmem_lsu_ctrl with a behavioural word memory attached
// (combinational read, synchronous write). Each task drives one scenario and
// compares the DUT against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_lsu_ctrl #(.MEM_BYTES(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] = mem_wdata;
  end

  // Issue one request with rsp_ready high and observe it to completion.
  // Returns latency (accept edge to rsp_valid, in cycles) and memory activity.
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output int nrd, output int nwr,
                         output int nboth, output logic [31:0] raddr,
                         output logic [31:0] wdat);
    logic done;
    lat = 0; nrd = 0; nwr = 0; nboth = 0;
    rdata = 32'h0; err = 1'b0; raddr = 32'h0; wdat = 32'h0; done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble the request bus: the DUT must work from its latched copy.
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    while (!done && lat < 10) begin
      lat++;
      @(negedge clk);
      if (mem_read)  begin nrd++; raddr = mem_addr; end
      if (mem_write) begin nwr++; wdat = mem_wdata; end
      if (mem_read && mem_write) nboth++;
      if (rsp_valid) begin
        done = 1'b1; rdata = rsp_rdata; err = rsp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++;
    if ({rsp_valid, rsp_err, mem_read, mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {rsp_valid, rsp_err, mem_read, mem_write});
    end
    n_checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {rsp_rdata, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    int lat, nrd, nwr, nb; logic [31:0] rd, ra, wd; logic er;
    mem[4] = 32'hDEAD_BEEF;
    run_req(1'b0, 3'b010, 32'h010, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
    n_checks++;
    if ({er, lat[3:0]} !== {1'b0, 4'd2}) begin n_fail++; $display("FAIL lw_err_lat: got err=%b lat=%0d expected err=0 lat=2", er, lat); end
    n_checks++;
    if ({nrd[3:0], nwr[3:0], ra} !== {4'd1, 4'd0, 32'h010}) begin
      n_fail++; $display("FAIL lw_mem: got rd=%0d wr=%0d addr=%h expected rd=1 wr=0 addr=010", nrd, nwr, ra);
    end
  endtask

  task automatic test_subword_loads;
    int lat, nrd, nwr, nb; logic [31:0] rd, ra, wd; logic er;
    mem[4] = 32'h80FF_1234;
    run_req(1'b0, 3'b000, 32'h013, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, rd} !== {1'b0, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb_013: got err=%b data=%h expected err=0 data=ffffff80", er, rd); end
    run_req(1'b0, 3'b100, 32'h013, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, rd} !== {1'b0, 32'h0000_0080}) begin n_fail++; $display("FAIL lbu_013: got err=%b data=%h expected err=0 data=00000080", er, rd); end
    run_req(1'b0, 3'b001, 32'h012, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, rd} !== {1'b0, 32'hFFFF_80FF}) begin n_fail++; $display("FAIL lh_012: got err=%b data=%h expected err=0 data=ffff80ff", er, rd); end
    run_req(1'b0, 3'b101, 32'h010, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, rd} !== {1'b0, 32'h0000_1234}) begin n_fail++; $display("FAIL lhu_010: got err=%b data=%h expected err=0 data=00001234", er, rd); end
    run_req(1'b0, 3'b000, 32'h011, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, rd} !== {1'b0, 32'h0000_0012}) begin n_fail++; $display("FAIL lb_011: got err=%b data=%h expected err=0 data=00000012", er, rd); end
    mem[255] = 32'h7F00_0000;
    run_req(1'b0, 3'b000, 32'h3FF, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, rd} !== {1'b0, 32'h0000_007F}) begin n_fail++; $display("FAIL lb_3ff: got err=%b data=%h expected err=0 data=0000007f", er, rd); end
  endtask

  task automatic test_stores;
    int lat, nrd, nwr, nb; logic [31:0] rd, ra, wd; logic er;
    mem[8] = 32'h1122_3344;
    run_req(1'b1, 3'b000, 32'h021, 32'h0000_00AB, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({nrd[3:0], nwr[3:0], nb[3:0], wd} !== {4'd1, 4'd1, 4'd0, 32'h1122_AB44}) begin
      n_fail++; $display("FAIL sb_mem: got rd=%0d wr=%0d both=%0d wdata=%h expected 1 1 0 1122ab44", nrd, nwr, nb, wd);
    end
    n_checks++;
    if ({er, rd, lat[3:0]} !== {1'b0, 32'h0, 4'd3}) begin
      n_fail++; $display("FAIL sb_rsp: got err=%b data=%h lat=%0d expected err=0 data=0 lat=3", er, rd, lat);
    end
    run_req(1'b0, 3'b010, 32'h020, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if (rd !== 32'h1122_AB44) begin n_fail++; $display("FAIL sb_readback: got %h expected 1122ab44", rd); end
    run_req(1'b1, 3'b001, 32'h022, 32'h0000_BEEF, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({mem[8], lat[3:0]} !== {32'hBEEF_AB44, 4'd3}) begin
      n_fail++; $display("FAIL sh_022: got word=%h lat=%0d expected word=beefab44 lat=3", mem[8], lat);
    end
    run_req(1'b1, 3'b010, 32'h024, 32'h1234_5678, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({mem[9], lat[3:0], nrd[3:0], nwr[3:0]} !== {32'h1234_5678, 4'd2, 4'd0, 4'd1}) begin
      n_fail++; $display("FAIL sw_024: got word=%h lat=%0d rd=%0d wr=%0d expected 12345678 2 0 1", mem[9], lat, nrd, nwr);
    end
  endtask

  task automatic test_errors;
    int lat, nrd, nwr, nb; logic [31:0] rd, ra, wd; logic er;
    logic [31:0] w8;
    w8 = mem[8];
    run_req(1'b1, 3'b001, 32'h023, 32'h0000_5A5A, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, lat[3:0], nrd[3:0], nwr[3:0], rd} !== {1'b1, 4'd1, 4'd0, 4'd0, 32'h0}) begin
      n_fail++; $display("FAIL sh_misaligned: got err=%b lat=%0d rd=%0d wr=%0d data=%h expected 1 1 0 0 0", er, lat, nrd, nwr, rd);
    end
    n_checks++;
    if (mem[8] !== w8) begin n_fail++; $display("FAIL sh_misaligned_mem: got %h expected %h", mem[8], w8); end
    run_req(1'b0, 3'b010, 32'h400, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, lat[3:0], nrd[3:0], nwr[3:0]} !== {1'b1, 4'd1, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL lw_range: got err=%b lat=%0d rd=%0d wr=%0d expected 1 1 0 0", er, lat, nrd, nwr);
    end
    run_req(1'b0, 3'b010, 32'h012, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, nrd[3:0]} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL lw_misaligned: got err=%b rd=%0d expected 1 0", er, nrd); end
    run_req(1'b0, 3'b011, 32'h010, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, nrd[3:0]} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL load_f3_011: got err=%b rd=%0d expected 1 0", er, nrd); end
    run_req(1'b1, 3'b100, 32'h010, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, nrd[3:0], nwr[3:0]} !== {1'b1, 4'd0, 4'd0}) begin n_fail++; $display("FAIL store_f3_100: got err=%b rd=%0d wr=%0d expected 1 0 0", er, nrd, nwr); end
  endtask

  task automatic test_back_to_back;
    mem[4] = 32'hA5A5_0001;
    mem[8] = 32'h0BAD_F00D;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h010;
    @(posedge clk); #1;
    // Second request held on the bus while the first is in flight.
    req_addr = 32'h020;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
        n_fail++; $display("FAIL hold_%0d: got valid=%b ready=%b data=%h expected 1 0 a5a50001", i, rsp_valid, req_ready, rsp_rdata);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req_ready, mem_read} !== 3'b010) begin
      n_fail++; $display("FAIL resp_to_idle: got valid=%b ready=%b mem_read=%b expected 0 1 0", rsp_valid, req_ready, mem_read);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h020}) begin
      n_fail++; $display("FAIL next_accept: got mem_read=%b addr=%h expected 1 020", mem_read, mem_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL next_rsp: got valid=%b data=%h expected 1 0badf00d", rsp_valid, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_rmw;
    int lat, nrd, nwr, nb; logic [31:0] rd, ra, wd; logic er;
    mem[12] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h030; req_wdata = 32'h0000_5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({mem_write, mem_wdata} !== {1'b1, 32'hCAFE_5555}) begin
      n_fail++; $display("FAIL rmw_wr_phase: got mem_write=%b wdata=%h expected 1 cafe5555", mem_write, mem_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_write, mem_read, rsp_valid, rsp_err, req_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_abort_ctrl: got %b expected 00001", {mem_write, mem_read, rsp_valid, rsp_err, req_ready});
    end
    n_checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL reset_abort_data: got %h expected 0", {rsp_rdata, mem_addr, mem_wdata});
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem[12] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL reset_abort_mem: got %h expected cafef00d", mem[12]); end
    rst_n = 1'b1;
    run_req(1'b0, 3'b010, 32'h030, 32'h0, lat, rd, er, nrd, nwr, nb, ra, wd);
    n_checks++;
    if ({er, rd} !== {1'b0, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL after_reset_lw: got err=%b data=%h expected 0 cafef00d", er, rd); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_lw();
    test_subword_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
